// File: rtl/dcache_pkg.sv
// Shared widths, address split and FSM state for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int unsigned C_BLOCK_SIZE = 2;
  localparam int unsigned C_LINE_SIZE  = 32;
  localparam int unsigned ADDRESS_SIZE = 32;
  localparam int unsigned C_INDEX_SIZE = 3;

  localparam int unsigned WORDS   = 1 << C_BLOCK_SIZE;
  localparam int unsigned LINES   = 1 << C_INDEX_SIZE;
  localparam int unsigned BLOCK_W = WORDS * C_LINE_SIZE;
  localparam int unsigned TAG_W   = ADDRESS_SIZE - C_INDEX_SIZE - C_BLOCK_SIZE - 2;
  localparam int unsigned BADDR_W = ADDRESS_SIZE - C_BLOCK_SIZE - 2;
  localparam int unsigned WADDR_W = ADDRESS_SIZE - 2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    ALLOCATE   = 2'd2,
    FILL       = 2'd3
  } state_e;

  // Word address viewed as {tag, index, offset}
  typedef struct packed {
    logic [TAG_W-1:0]        tag;
    logic [C_INDEX_SIZE-1:0] index;
    logic [C_BLOCK_SIZE-1:0] offset;
  } addr_fields_t;

  function automatic addr_fields_t split_addr(input logic [ADDRESS_SIZE-1:0] addr);
    return addr_fields_t'(addr[ADDRESS_SIZE-1:2]);
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Per-line valid/dirty/tag/data storage: combinational read port, synchronous word or block write.
module dcache_line_array
  import dcache_pkg::*;
(
  input  logic                    c_clk_i,
  input  logic                    c_reset_n_i,
  input  logic [C_INDEX_SIZE-1:0] rd_index,
  output logic                    rd_valid,
  output logic                    rd_dirty,
  output logic [TAG_W-1:0]        rd_tag,
  output logic [BLOCK_W-1:0]      rd_block,
  input  logic [C_INDEX_SIZE-1:0] wr_index,
  input  logic                    word_we,
  input  logic [C_BLOCK_SIZE-1:0] wr_offset,
  input  logic [C_LINE_SIZE-1:0]  wr_word,
  input  logic                    fill_we,
  input  logic [TAG_W-1:0]        fill_tag,
  input  logic [BLOCK_W-1:0]      fill_block
);

  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];

  // Status bits clear asynchronously; a fill leaves the line clean
  always_ff @(posedge c_clk_i or negedge c_reset_n_i) begin
    if (!c_reset_n_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[wr_index] <= 1'b1;
      dirty_q[wr_index] <= 1'b0;
    end else if (word_we) begin
      dirty_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data arrays are never reset; valid qualifies them
  always_ff @(posedge c_clk_i) begin
    if (fill_we) begin
      tag_q[wr_index]  <= fill_tag;
      data_q[wr_index] <= fill_block;
    end else if (word_we) begin
      data_q[wr_index][int'(wr_offset)*C_LINE_SIZE +: C_LINE_SIZE] <= wr_word;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_block = data_q[rd_index];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache controller in front of a block-wide dmemory.
// Define DCACHE_STATS_EN to add saturating hit/miss counters.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic                      c_clk_i,
  input  logic                      c_reset_n_i,
  input  logic                      c_read_i,
  input  logic                      c_write_i,
  input  logic [ADDRESS_SIZE-1:0]   c_addr_i,
  input  logic [C_LINE_SIZE-1:0]    c_wr_data_i,
  output logic [C_LINE_SIZE-1:0]    c_read_data_o,
  output logic                      c_busywait_o,
  output logic                      mem_read_o,
  output logic                      mem_write_o,
  output logic [BADDR_W-1:0]        mem_addr_o,
  output logic [BLOCK_W-1:0]        mem_wr_data_o,
  input  logic [BLOCK_W-1:0]        mem_rd_data_i,
  input  logic                      mem_busywait_i,
  input  logic                      mem_read_done_i,
  input  logic                      mem_write_done_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]               hit_count_o,
  output logic [31:0]               miss_count_o
`endif
);

  state_e                  state_q;
  logic [TAG_W-1:0]        miss_tag_q;
  logic [C_INDEX_SIZE-1:0] miss_idx_q;
  logic                    mem_read_q;
  logic                    mem_write_q;
  logic [BADDR_W-1:0]      mem_addr_q;

  addr_fields_t            cur;
  logic                    req;
  logic                    is_idle;
  logic                    hit;
  logic                    hit_evt;
  logic                    miss_evt;
  logic [C_INDEX_SIZE-1:0] rd_index;
  logic [C_INDEX_SIZE-1:0] wr_index;
  logic                    line_valid;
  logic                    line_dirty;
  logic [TAG_W-1:0]        line_tag;
  logic [BLOCK_W-1:0]      line_block;
  logic                    word_we;
  logic                    fill_we;

  // Memory busy and the byte-lane address bits are observed only
  logic unused_inputs;
  assign unused_inputs = ^{mem_busywait_i, c_addr_i[1:0]};

  assign cur     = split_addr(c_addr_i);
  assign req     = c_read_i | c_write_i;
  assign is_idle = (state_q == IDLE);

  // While a miss is in flight the array stays pointed at the latched line
  assign rd_index = is_idle ? cur.index : miss_idx_q;
  assign wr_index = fill_we ? miss_idx_q : cur.index;

  dcache_line_array u_lines (
    .c_clk_i     (c_clk_i),
    .c_reset_n_i (c_reset_n_i),
    .rd_index    (rd_index),
    .rd_valid    (line_valid),
    .rd_dirty    (line_dirty),
    .rd_tag      (line_tag),
    .rd_block    (line_block),
    .wr_index    (wr_index),
    .word_we     (word_we),
    .wr_offset   (cur.offset),
    .wr_word     (c_wr_data_i),
    .fill_we     (fill_we),
    .fill_tag    (miss_tag_q),
    .fill_block  (mem_rd_data_i)
  );

  assign hit      = line_valid && (line_tag == cur.tag);
  assign hit_evt  = is_idle && req && hit;
  assign miss_evt = is_idle && req && !hit;
  assign word_we  = hit_evt && c_write_i;
  assign fill_we  = (state_q == ALLOCATE) && mem_read_done_i;

  // CPU side is combinational so hits complete with no wait
  assign c_busywait_o  = req && !(is_idle && hit);
  assign c_read_data_o = (hit_evt && !c_write_i)
                         ? line_block[int'(cur.offset)*C_LINE_SIZE +: C_LINE_SIZE]
                         : '0;

  assign mem_read_o    = mem_read_q;
  assign mem_write_o   = mem_write_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wr_data_o = mem_write_q ? line_block : '0;

  // Miss FSM; memory requests are registered alongside the state
  always_ff @(posedge c_clk_i or negedge c_reset_n_i) begin
    if (!c_reset_n_i) begin
      state_q     <= IDLE;
      miss_tag_q  <= '0;
      miss_idx_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (miss_evt) begin
            miss_tag_q <= cur.tag;
            miss_idx_q <= cur.index;
            if (line_valid && line_dirty) begin
              state_q     <= WRITE_BACK;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {line_tag, cur.index};
            end else begin
              state_q    <= ALLOCATE;
              mem_read_q <= 1'b1;
              mem_addr_q <= {cur.tag, cur.index};
            end
          end
        end
        WRITE_BACK: begin
          if (mem_write_done_i) begin
            state_q     <= ALLOCATE;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b1;
            mem_addr_q  <= {miss_tag_q, miss_idx_q};
          end
        end
        ALLOCATE: begin
          if (mem_read_done_i) begin
            state_q    <= FILL;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
          end
        end
        FILL: begin
          state_q <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          mem_addr_q  <= '0;
        end
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  // Saturating access statistics
  always_ff @(posedge c_clk_i or negedge c_reset_n_i) begin
    if (!c_reset_n_i) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (hit_evt && (hit_count_q != '1)) begin
        hit_count_q <= hit_count_q + 32'd1;
      end
      if (miss_evt && (miss_count_q != '1)) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  assign hit_count_o  = hit_count_q;
  assign miss_count_o = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a block-wide dmemory model and traffic/read-data scoreboards.
`timescale 1ns/1ps
module tb_dcache_controller;

  localparam int unsigned BLOCK_W   = 128;
  localparam int unsigned BADDR_W   = 28;
  localparam int unsigned MEM_WORDS = 1024;
  localparam int unsigned MEM_LAT   = 3;
  localparam int unsigned TIMEOUT   = 200;

  typedef struct packed {
    logic               wr;
    logic [BADDR_W-1:0] addr;
    logic [31:0]        word1;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               c_read;
  logic               c_write;
  logic [31:0]        c_addr;
  logic [31:0]        c_wr_data;
  logic [31:0]        c_read_data;
  logic               c_busywait;
  logic               mem_read;
  logic               mem_write;
  logic [BADDR_W-1:0] mem_addr;
  logic [BLOCK_W-1:0] mem_wr_data;
  logic [BLOCK_W-1:0] mem_rd_data = '0;
  logic               mem_busy;
  logic               mem_read_done = 1'b0;
  logic               mem_write_done = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0]        hit_count;
  logic [31:0]        miss_count;
`endif

  dcache_controller u_dut (
    .c_clk_i          (clk),
    .c_reset_n_i      (rst_n),
    .c_read_i         (c_read),
    .c_write_i        (c_write),
    .c_addr_i         (c_addr),
    .c_wr_data_i      (c_wr_data),
    .c_read_data_o    (c_read_data),
    .c_busywait_o     (c_busywait),
    .mem_read_o       (mem_read),
    .mem_write_o      (mem_write),
    .mem_addr_o       (mem_addr),
    .mem_wr_data_o    (mem_wr_data),
    .mem_rd_data_i    (mem_rd_data),
    .mem_busywait_i   (mem_busy),
    .mem_read_done_i  (mem_read_done),
    .mem_write_done_i (mem_write_done)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count_o      (hit_count),
    .miss_count_o     (miss_count)
`endif
  );

  function automatic logic [31:0] init_word(input int unsigned i);
    return (i == 16) ? 32'hDEAD_BEEF : (32'hA500_0000 | 32'(i));
  endfunction

  // dmemory model: fixed latency, one-cycle done pulse, block word 0 in the LSBs
  logic [31:0] dmem [MEM_WORDS];
  logic        mem_ready = 1'b0;
  int unsigned mem_cnt = 0;
  assign mem_busy = (mem_read || mem_write) && !mem_read_done && !mem_write_done;

  always @(posedge clk) begin
    mem_read_done  <= 1'b0;
    mem_write_done <= 1'b0;
    if (!mem_ready) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) dmem[i] <= init_word(i);
      mem_ready <= 1'b1;
      mem_cnt   <= 0;
    end else if (!rst_n) begin
      mem_cnt <= 0;
    end else if (mem_busy) begin
      if (mem_cnt == MEM_LAT) begin
        mem_cnt <= 0;
        for (int w = 0; w < 4; w++) begin
          if (mem_write) dmem[(int'(mem_addr) * 4 + w) % MEM_WORDS] <= mem_wr_data[32*w +: 32];
          else           mem_rd_data[32*w +: 32] <= dmem[(int'(mem_addr) * 4 + w) % MEM_WORDS];
        end
        if (mem_write) mem_write_done <= 1'b1;
        else           mem_read_done  <= 1'b1;
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  // Records each new memory request as the DUT issues it
  txn_t obs_q[$];
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;
  always @(negedge clk) begin
    txn_t t;
    if (mem_read && !prev_rd) begin
      t.wr = 1'b0; t.addr = mem_addr; t.word1 = mem_wr_data[63:32];
      obs_q.push_back(t);
    end
    if (mem_write && !prev_wr) begin
      t.wr = 1'b1; t.addr = mem_addr; t.word1 = mem_wr_data[63:32];
      obs_q.push_back(t);
    end
    prev_rd <= mem_read;
    prev_wr <= mem_write;
  end

  logic [31:0] shadow [MEM_WORDS];
  logic [31:0] rd_exp_q[$];
  txn_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_txn(input logic wr, input logic [BADDR_W-1:0] addr, input logic [31:0] word1);
    txn_t t;
    t.wr = wr; t.addr = addr; t.word1 = word1;
    exp_q.push_back(t);
  endtask

  task automatic check_traffic(input string tag);
    txn_t e;
    txn_t o;
    check({tag, "_txn_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, "_txn_kind"}, 32'(o.wr), 32'(e.wr));
      check({tag, "_txn_addr"}, 32'(o.addr), 32'(e.addr));
      check({tag, "_txn_word1"}, o.word1, e.word1);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // One CPU access: held until busywait drops; read data popped from the scoreboard
  task automatic cpu_access(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, output int stall);
    logic [31:0] exp;
    @(negedge clk);
    c_read = !wr; c_write = wr; c_addr = addr; c_wr_data = wdata;
    if (wr) shadow[addr[11:2]] = wdata;
    else    rd_exp_q.push_back(shadow[addr[11:2]]);
    stall = 0;
    #1;
    while (c_busywait === 1'b1 && stall < int'(TIMEOUT)) begin
      @(negedge clk); #1;
      stall++;
    end
    check({tag, "_busy_timeout"}, 32'(c_busywait), 32'h0);
    if (!wr) begin
      exp = rd_exp_q.pop_front();
      check({tag, "_rd_data"}, c_read_data, exp);
    end
    @(posedge clk); #1;
    c_read = 1'b0; c_write = 1'b0;
  endtask

  initial begin
    int stall;
    int waited;
    for (int i = 0; i < int'(MEM_WORDS); i++) shadow[i] = init_word(i);
    rst_n = 1'b0; c_read = 1'b0; c_write = 1'b0; c_addr = '0; c_wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busywait", 32'(c_busywait), 32'h0);
    check("rst_mem_read", 32'(mem_read), 32'h0);
    check("rst_mem_write", 32'(mem_write), 32'h0);
    check("rst_read_data", c_read_data, 32'h0);
    rst_n = 1'b1;

    // Cold read miss then repeat hit
    expect_txn(1'b0, 28'h004, 32'h0);
    cpu_access("cold_miss", 1'b0, 32'h0000_0040, 32'h0, stall);
    check("cold_miss_stalled", 32'(stall != 0), 32'h1);
    check_traffic("cold_miss");
    cpu_access("rehit", 1'b0, 32'h0000_0040, 32'h0, stall);
    check("rehit_stall", 32'(stall), 32'h0);
    check_traffic("rehit");

    // Write hit then read back, no traffic
    cpu_access("wr_hit", 1'b1, 32'h0000_0044, 32'h1234_5678, stall);
    check("wr_hit_stall", 32'(stall), 32'h0);
    cpu_access("rd_after_wr", 1'b0, 32'h0000_0044, 32'h0, stall);
    check("rd_after_wr_stall", 32'(stall), 32'h0);
    check_traffic("wr_hit");
    check("dirty4", 32'(u_dut.u_lines.dirty_q[4]), 32'h1);

    // Dirty eviction of index 4
    expect_txn(1'b1, 28'h004, 32'h1234_5678);
    expect_txn(1'b0, 28'h024, 32'h0);
    cpu_access("evict", 1'b0, 32'h0000_0240, 32'h0, stall);
    check_traffic("evict");
    check("evict_dmem_0x11", dmem[17], 32'h1234_5678);

    // Clean-miss replacement, reads only
    expect_txn(1'b0, 28'h004, 32'h0);
    cpu_access("clean_a", 1'b0, 32'h0000_0040, 32'h0, stall);
    check_traffic("clean_a");
    expect_txn(1'b0, 28'h024, 32'h0);
    cpu_access("clean_b", 1'b0, 32'h0000_0240, 32'h0, stall);
    check_traffic("clean_b");

    // Write miss allocates, then hits
    expect_txn(1'b0, 28'h008, 32'h0);
    cpu_access("wr_miss", 1'b1, 32'h0000_0084, 32'h0BAD_F00D, stall);
    check("wr_miss_stalled", 32'(stall != 0), 32'h1);
    cpu_access("wr_miss_rd", 1'b0, 32'h0000_0084, 32'h0, stall);
    check("wr_miss_rd_stall", 32'(stall), 32'h0);
    check_traffic("wr_miss");

    // Reset mid-ALLOCATE: 0x40 is resident, then a 0x240 miss is abandoned
    expect_txn(1'b0, 28'h004, 32'h0);
    cpu_access("pre_rst", 1'b0, 32'h0000_0040, 32'h0, stall);
    check_traffic("pre_rst");
    expect_txn(1'b0, 28'h024, 32'h0);
    @(negedge clk);
    c_read = 1'b1; c_addr = 32'h0000_0240;
    waited = 0;
    while (mem_read !== 1'b1 && waited < int'(TIMEOUT)) begin
      @(negedge clk);
      waited++;
    end
    check("alloc_reached", 32'(mem_read), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_drops_mem_read", 32'(mem_read), 32'h0);
    c_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_traffic("rst_abort");

    // Post-reset sequence: 3 misses, 5 completed hits
    expect_txn(1'b0, 28'h004, 32'h0);
    cpu_access("post_rst_miss", 1'b0, 32'h0000_0040, 32'h0, stall);
    check("post_rst_miss_stalled", 32'(stall != 0), 32'h1);
    check_traffic("post_rst_miss");
    cpu_access("post_hit_rd", 1'b0, 32'h0000_0044, 32'h0, stall);
    cpu_access("post_hit_wr", 1'b1, 32'h0000_0048, 32'hCAFE_F00D, stall);
    check("post_hit_wr_stall", 32'(stall), 32'h0);
    expect_txn(1'b1, 28'h004, 32'h1234_5678);
    expect_txn(1'b0, 28'h024, 32'h0);
    cpu_access("post_evict", 1'b0, 32'h0000_0240, 32'h0, stall);
    check_traffic("post_evict");
    check("post_evict_dmem_0x12", dmem[18], 32'hCAFE_F00D);
    expect_txn(1'b0, 28'h004, 32'h0);
    cpu_access("post_refill", 1'b0, 32'h0000_0040, 32'h0, stall);
    check_traffic("post_refill");
`ifdef DCACHE_STATS_EN
    @(negedge clk);
    check("stats_miss", miss_count, 32'd3);
    check("stats_hit", hit_count, 32'd5);
`endif
    check("rd_scoreboard_empty", 32'(rd_exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache that sits between the CPU load/store stage and the block-wide data memory (dmemory).
- Serves word reads and writes from the CPU. Hits complete with zero wait.
- On a miss it evicts a dirty victim block to memory, then fills the requested block using dmemory's request/done handshake.

Parameters:
- c_block_size, 2, log2 of words per block (4 words).
- c_line_size, 32, word width in bits.
- address_size, 32, CPU byte-address width.
- c_index_size, 3, log2 of number of cache lines (8 lines).
- Derived: tag width TW = address_size - c_index_size - c_block_size - 2.

Ports:
- c_clk_i  in  1  clock.
- c_reset_n_i  in  1  reset, asynchronous, active-low.
- c_read_i  in  1  CPU load request, held until busywait is low.
- c_write_i  in  1  CPU store request, held until busywait is low.
- c_addr_i  in  address_size  CPU byte address; bits [1:0] are ignored.
- c_wr_data_i  in  c_line_size  store data.
- c_read_data_o  out  c_line_size  load data.
- c_busywait_o  out  1  CPU stall.
- mem_read_o  out  1  block read request to dmemory.
- mem_write_o  out  1  block write request to dmemory.
- mem_addr_o  out  address_size-c_block_size-2  block address.
- mem_wr_data_o  out  2**c_block_size*c_line_size  victim block.
- mem_rd_data_i  in  2**c_block_size*c_line_size  fill block; word 0 is in the LSBs.
- mem_busywait_i  in  1  memory busy (monitored only).
- mem_read_done_i  in  1  one-cycle pulse; fill data valid this cycle.
- mem_write_done_i  in  1  one-cycle pulse; write-back complete.

Behaviour:
- Address split:
  - offset = c_addr_i[c_block_size+1:2]
  - index = next c_index_size bits
  - tag = upper TW bits
- Storage per line: valid, dirty, tag, data block.
- Reset, asynchronous, while c_reset_n_i = 0:
  - All valid and dirty bits cleared; state = IDLE.
  - mem_read_o, mem_write_o, c_busywait_o and c_read_data_o are 0.
  - Data arrays are not cleared.
  - Reset asserted mid-miss abandons the transaction; memory requests drop immediately.
- hit = valid[index] && tag match.
- c_busywait_o = (c_read_i | c_write_i) && !(state == IDLE && hit). It is combinational.
- Read hit: c_read_data_o = the selected word, combinational, same cycle. Otherwise c_read_data_o holds 0.
- Write hit: the word is written at the posedge and dirty is set. No stall.
- c_read_i and c_write_i asserted together is treated as a write.
- FSM states:
  - IDLE:
    - Request and miss with dirty victim -> WRITE_BACK.
    - Request and miss with clean or invalid victim -> ALLOCATE.
  - WRITE_BACK:
    - mem_write_o = 1, mem_addr_o = {victim tag, index}, mem_wr_data_o = victim block.
    - On mem_write_done_i -> ALLOCATE.
  - ALLOCATE:
    - mem_read_o = 1, mem_addr_o = {req tag, index}.
    - On mem_read_done_i, capture mem_rd_data_i into the line, set tag, valid = 1, dirty = 0 -> FILL.
  - FILL: one cycle, no memory request -> IDLE. The next IDLE cycle is a hit and completes the access.
- Requests are state-decoded. They deassert in the cycle after the done pulse, so dmemory returns to IDLE without relaunching.
- Done pulses outside their matching state are ignored.
- CPU request dropped mid-miss: the FSM still completes the fill and returns to IDLE.
- mem_addr_o and mem_wr_data_o are 0 in IDLE and FILL.

Optional Feature:
- DCACHE_STATS_EN defined: adds outputs hit_count_o and miss_count_o, 32 bits each.
  - Counters reset to 0.
  - Hit counter increments once per completed hit cycle in IDLE.
  - Miss counter increments once per IDLE->miss transition.
  - Both saturate at all-ones.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package dcache_pkg holds:
  - state enum (IDLE, WRITE_BACK, ALLOCATE, FILL)
  - default widths
  - TW / index / offset derivation constants
- One sub-module, dcache_line_array: valid, dirty, tag and data storage with asynchronous clear of valid/dirty, a combinational read port and a synchronous word/block write port. The FSM stays in the top level.

Test Plan:
- Cold read miss, addr 0x0000_0040, mem.data word 0x10 = 0xDEADBEEF:
  - ALLOCATE issues mem_addr_o = 0x004.
  - Busywait drops after FILL; c_read_data_o = 0xDEADBEEF.
  - Repeat read: hit, busywait stays 0.
- Write hit to 0x44 with 0x12345678, then read 0x44:
  - Read returns 0x12345678 with zero stall.
  - No memory traffic; dirty[4] = 1.
- Dirty eviction:
  - Setup: after the previous test, read 0x0000_0240 (same index 4, different tag).
  - Response: WRITE_BACK to mem_addr_o = 0x004 carrying 0x12345678 in word 1, then ALLOCATE of 0x024. dmemory word 0x11 = 0x12345678 afterwards.
- Clean-miss replacement: read 0x40, then 0x240 with no writes -> no mem_write_o, only mem_read_o.
- Reset mid-ALLOCATE: pulse c_reset_n_i low for 1 cycle -> mem_read_o falls asynchronously; read of 0x40 misses again.
- With DCACHE_STATS_EN: sequence of 3 misses and 5 hits -> miss_count_o = 3, hit_count_o = 5.
